// File: rtl/ama_riscv_defines.sv
// Shared memory-bus widths and payload types for the cache-to-memory path.
package ama_riscv_defines;

    localparam int unsigned MEM_DATA_BUS         = 128;
    localparam int unsigned MEM_ADDR_BUS         = 32;
    localparam int unsigned MEM_TRANSFERS_PER_CL = 4;

    typedef logic [MEM_DATA_BUS-1:0] mem_block_t;

endpackage

// File: rtl/rv_if.sv
// Ready/valid handshake bundle; TX drives valid/data, RX drives ready.
interface rv_if #(
    parameter int unsigned DW = 32
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);

endinterface

// File: rtl/ama_riscv_sync_fifo.sv
// Synchronous FIFO with synchronous clear; head shows the oldest entry.
module ama_riscv_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ama_riscv_mem_responder.sv
// Main-memory block responder: fixed-latency in-order reads with credit backpressure.
// Optional MEM_RSP_BOUNDS_CHECK_EN adds a sticky oob_err and zero data for out-of-range blocks.
module ama_riscv_mem_responder
    import ama_riscv_defines::*;
#(
    parameter int unsigned MEM_BLOCKS = 1024,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    rv_if.RX                        req,
    rv_if.TX                        rsp,
    input  logic                    wr_en,
    input  logic [MEM_ADDR_BUS-1:0] wr_addr,
    input  mem_block_t              wr_data
`ifdef MEM_RSP_BOUNDS_CHECK_EN
    ,
    output logic                    oob_err
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_BLOCKS);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    mem_block_t       mem [MEM_BLOCKS];
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             rsp_fire;
    logic             q_empty;
    logic             unused_q_full;
    logic             q_push;
    logic             q_pop;
    mem_block_t       q_head;
    logic [LATENCY-1:0] pipe_v;
    mem_block_t       pipe_d [LATENCY];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    mem_block_t       rd_block;
    logic             wr_allow;

    assign rd_idx = req.data[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];

`ifdef MEM_RSP_BOUNDS_CHECK_EN
    logic rd_oob;
    logic wr_oob;

    assign rd_oob   = (req.data >= MEM_ADDR_BUS'(MEM_BLOCKS));
    assign wr_oob   = (wr_addr >= MEM_ADDR_BUS'(MEM_BLOCKS));
    assign rd_block = rd_oob ? '0 : mem[rd_idx];
    assign wr_allow = wr_en && !wr_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if ((accept && rd_oob) || (wr_en && wr_oob)) begin
            oob_err <= 1'b1;
        end
    end

`ifndef SYNT
    always_ff @(posedge clk) begin
        if (!rst && accept && rd_oob) $display("mem_responder: out-of-range read addr 0x%0h", req.data);
        if (!rst && wr_en && wr_oob)  $display("mem_responder: out-of-range write addr 0x%0h", wr_addr);
    end
`endif
`else
    logic unused_addr_hi;

    // Upper address bits wrap modulo MEM_BLOCKS.
    assign unused_addr_hi = ^{req.data[MEM_ADDR_BUS-1:IDX_W], wr_addr[MEM_ADDR_BUS-1:IDX_W]};
    assign rd_block       = mem[rd_idx];
    assign wr_allow       = wr_en;
`endif

    assign req.ready = !rst && !flush && (cnt < CNT_W'(QDEPTH));
    assign accept    = req.valid && req.ready;

    // Queue head has priority; an empty queue lets the pipe output bypass straight out.
    assign rsp.valid = !rst && !flush && (!q_empty || pipe_v[LATENCY-1]);
    assign rsp.data  = rsp.valid ? (q_empty ? pipe_d[LATENCY-1] : q_head) : '0;
    assign rsp_fire  = rsp.valid && rsp.ready;
    assign q_pop     = rsp_fire && !q_empty;
    assign q_push    = pipe_v[LATENCY-1] && !(q_empty && rsp_fire);

    always_ff @(posedge clk) begin
        if (wr_allow) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (accept && !rsp_fire) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!accept && rsp_fire) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= accept;
            for (int i = 1; i < int'(LATENCY); i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Stage 0 is the registered array read; later stages only delay it.
    always_ff @(posedge clk) begin
        if (accept) pipe_d[0] <= rd_block;
        for (int i = 1; i < int'(LATENCY); i++) pipe_d[i] <= pipe_d[i-1];
    end

    ama_riscv_sync_fifo #(
        .DEPTH (QDEPTH),
        .W     (MEM_DATA_BUS)
    ) u_rsp_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (q_push),
        .push_data (pipe_d[LATENCY-1]),
        .pop       (q_pop),
        .full      (unused_q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

endmodule

// File: tb/tb_ama_riscv_mem_responder.sv
// Bench for ama_riscv_mem_responder: directed steps plus random traffic against a timestamped queue model.
module tb_ama_riscv_mem_responder;
    import ama_riscv_defines::*;

    localparam int unsigned NB  = 1024;
    localparam int unsigned LAT = 3;
    localparam int unsigned QD  = 4;

    typedef struct {
        logic [127:0] data;
        int           avail;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    wr_en;
    logic [MEM_ADDR_BUS-1:0] wr_addr;
    logic [127:0]            wr_data;
`ifdef MEM_RSP_BOUNDS_CHECK_EN
    logic                    oob_err;
`endif

    rv_if #(.DW(MEM_ADDR_BUS)) req_if ();
    rv_if #(.DW(MEM_DATA_BUS)) rsp_if ();

    ama_riscv_mem_responder #(
        .MEM_BLOCKS (NB),
        .LATENCY    (LAT),
        .QDEPTH     (QD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .req     (req_if),
        .rsp     (rsp_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
`ifdef MEM_RSP_BOUNDS_CHECK_EN
        ,
        .oob_err (oob_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    int           nfire  = 0;
    bit           oob_m  = 1'b0;
    exp_t         q[$];
    logic [127:0] mem_m [NB];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        bit           p_ready;
        bit           p_valid;
        bit           acc;
        bit           fire;
        logic [127:0] p_data;
        exp_t         e;
        #1;
        p_ready = !rst && !flush && (q.size() < int'(QD));
        p_valid = !rst && !flush && (q.size() > 0) && (q[0].avail <= cyc);
        p_data  = p_valid ? q[0].data : '0;
        chk("req_ready", req_if.ready, p_ready);
        if (!flush || rst) chk("rsp_valid", rsp_if.valid, p_valid);
        if (p_valid || rst) chk("rsp_data", rsp_if.data, p_data);
`ifdef MEM_RSP_BOUNDS_CHECK_EN
        chk("oob_err", oob_err, oob_m);
`endif
        acc  = req_if.valid && p_ready;
        fire = p_valid && rsp_if.ready;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (fire) begin
                void'(q.pop_front());
                nfire++;
            end
            if (acc) begin
                e.avail = cyc + int'(LAT);
`ifdef MEM_RSP_BOUNDS_CHECK_EN
                if (req_if.data >= NB) begin
                    e.data = '0;
                    oob_m  = 1'b1;
                end else begin
                    e.data = mem_m[req_if.data % NB];
                end
`else
                e.data = mem_m[req_if.data % NB];
`endif
                q.push_back(e);
            end
        end
        if (wr_en) begin
`ifdef MEM_RSP_BOUNDS_CHECK_EN
            if (wr_addr >= NB) oob_m = 1'b1;
            else mem_m[wr_addr % NB] = wr_data;
`else
            mem_m[wr_addr % NB] = wr_data;
`endif
        end
        if (rst) oob_m = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int start;
        rst          = 1'b1;
        flush        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        req_if.valid = 1'b0;
        req_if.data  = '0;
        rsp_if.ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Preload every block so reads are deterministic, then the 0x40..0x43 pattern.
        for (int i = 0; i < int'(NB); i++) begin
            wr_en   = 1'b1;
            wr_addr = MEM_ADDR_BUS'(i);
            wr_data = {4{32'hC0DE_0000 | 32'(i)}};
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            wr_addr = MEM_ADDR_BUS'(32'h40 + i);
            wr_data = {16{8'(8'hA0 + i)}};
            tick();
        end
        wr_en = 1'b0;

        // Back-to-back reads stream out on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            req_if.valid = 1'b1;
            req_if.data  = MEM_ADDR_BUS'(32'h40 + i);
            tick();
        end
        req_if.valid = 1'b0;
        repeat (LAT + 3) tick();

        // Stalled response side: only QD requests get credit.
        rsp_if.ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_if.valid = 1'b1;
            req_if.data  = MEM_ADDR_BUS'(32'h20 + i);
            tick();
        end
        req_if.valid = 1'b0;
        repeat (2) tick();
        rsp_if.ready = 1'b1;
        repeat (LAT + 6) tick();

        // Flush one cycle after the second response, then a fresh read of 0x10.
        start = nfire;
        for (int i = 0; i < 4; i++) begin
            req_if.valid = 1'b1;
            req_if.data  = MEM_ADDR_BUS'(32'h40 + i);
            tick();
        end
        req_if.valid = 1'b0;
        for (int k = 0; k < 20 && nfire < start + 2; k++) tick();
        chk("flush_wait", 128'(nfire >= start + 2), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_if.valid = 1'b1;
        req_if.data  = MEM_ADDR_BUS'(32'h10);
        tick();
        req_if.valid = 1'b0;
        repeat (LAT + 3) tick();

        // Same-cycle write returns old data; the following read sees the new block.
        wr_en        = 1'b1;
        wr_addr      = MEM_ADDR_BUS'(32'h7);
        wr_data      = {16{8'h55}};
        req_if.valid = 1'b1;
        req_if.data  = MEM_ADDR_BUS'(32'h7);
        tick();
        wr_en = 1'b0;
        tick();
        req_if.valid = 1'b0;
        repeat (LAT + 3) tick();

        // Address beyond the array: wraps, or zero data plus oob_err when checked.
        req_if.valid = 1'b1;
        req_if.data  = MEM_ADDR_BUS'(32'h405);
        tick();
        req_if.valid = 1'b0;
        repeat (LAT + 3) tick();

        // Random traffic with occasional flushes and colliding writes.
        for (int n = 0; n < 400; n++) begin
            flush        = ($urandom_range(0, 39) == 0);
            req_if.valid = ($urandom_range(0, 2) != 0);
            req_if.data  = MEM_ADDR_BUS'($urandom_range(0, 15) + (($urandom_range(0, 5) == 0) ? 1024 : 0));
            rsp_if.ready = ($urandom_range(0, 3) != 0);
            wr_en        = !flush && ($urandom_range(0, 4) == 0);
            wr_addr      = MEM_ADDR_BUS'($urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? 1024 : 0));
            wr_data      = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        flush        = 1'b0;
        wr_en        = 1'b0;
        req_if.valid = 1'b0;
        rsp_if.ready = 1'b1;
        repeat (LAT + 6) tick();

        // Reset with three responses pending drops them all.
        rsp_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_if.valid = 1'b1;
            req_if.data  = MEM_ADDR_BUS'(32'h40 + i);
            tick();
        end
        req_if.valid = 1'b0;
        repeat (LAT) tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        rsp_if.ready = 1'b1;
        repeat (LAT + 6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ama_riscv_mem_responder.md
Name: ama_riscv_mem_responder

Overview:
- Main-memory responder for the cache-to-memory rv_if.
- Accepts 16B-block read addresses from a cache miss engine (icache/dcache) and returns 128-bit blocks in order after a fixed, parameterised latency.
- Backpressure on the request side is driven by an outstanding-request credit count.
- A loader write port initialises and patches the array, and a flush input drops every in-flight response on wrong-path speculation.

Parameters:
- MEM_BLOCKS, 1024: number of 128-bit blocks in the array; power of 2, at least 4.
- LATENCY, 1: cycles from request accept to the earliest rsp.valid; range 1..8.
- QDEPTH, 4: maximum outstanding requests (pipe plus response queue); power of 2, at least MEM_TRANSFERS_PER_CL.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all outstanding requests and responses (driven by spec.wrong)
- req  rv_if.RX  MEM_ADDR_BUS  block address (valid/ready/data)
- rsp  rv_if.TX  MEM_DATA_BUS (128)  block read data (valid/ready/data)
- wr_en  in  1  loader write strobe
- wr_addr  in  MEM_ADDR_BUS  loader block address
- wr_data  in  128  loader block data

Behaviour:
- Reset: rsp.valid=0, rsp.data=0, req.ready=0 for the reset cycle. Outstanding count=0; pipe and queue empty. Array contents are not reset.
- Reset mid-burst discards everything in flight; no response is emitted after reset.
- Accept: occurs when req.valid && req.ready. req.ready = !rst && (outstanding < QDEPTH).
- Array read: registered at accept, indexed by addr[$clog2(MEM_BLOCKS)-1:0]; upper bits wrap (modulo).
- Latency: read data passes through LATENCY-1 valid/data pipe stages, then enters an in-order response queue of depth QDEPTH.
- Bypass: when the queue is empty and the pipe output is valid, the pipe output drives rsp directly. A request accepted at cycle T therefore gives rsp.valid at T+LATENCY with no stall.
- Throughput: back-to-back accepts give back-to-back responses (one per cycle) while rsp.ready=1.
- Response handshake: rsp.valid reflects the queue head (or bypass). The entry pops on rsp.valid && rsp.ready. rsp.data must hold stable while rsp.valid && !rsp.ready.
- Pipe output arriving while rsp is stalled or the queue is non-empty is pushed to the queue tail. Overflow is impossible by construction of the credit count.
- Credit count: +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged. req.ready=0 at outstanding==QDEPTH, and reasserts in the cycle after a pop.
- Flush: priority over everything in the same cycle.
  - Pipe valids cleared, queue emptied, count set to 0.
  - A request presented in the flush cycle is not accepted (req.ready=0 that cycle).
  - rsp.valid=0 in the cycle after flush.
- Writes: the array updates at the clock edge.
  - A read accepted in the same cycle as a write to the same block returns the old data.
  - A read accepted one cycle later returns the new data.
  - Writes never affect the credit count and have no handshake.
- Ordering: strict in-order; responses never reorder or duplicate.

Optional Feature:
- Macro: MEM_RSP_BOUNDS_CHECK_EN.
- Defined:
  - An output port oob_err (1 bit, sticky, reset 0) is added.
  - A request whose address is >= MEM_BLOCKS still completes normally but returns rsp.data=0 and sets oob_err.
  - Loader writes to out-of-range addresses are ignored and also set oob_err.
  - Sim builds (`ifndef SYNT) additionally log the offending address.
- Undefined: no oob_err port; addresses wrap modulo MEM_BLOCKS for both reads and writes.

Decomposition:
- Shared package (ama_riscv_defines): MEM_DATA_BUS, MEM_ADDR_BUS and MEM_TRANSFERS_PER_CL, all existing; add mem_block_t as a packed 128-bit type.
- Sub-module ama_riscv_sync_fifo: parameters DEPTH and W; push/pop/full/empty/head; synchronous clear; synchronous reset.
  - Used for the response queue.
  - The latency pipe and credit counter stay in the top module.

Test Plan:
- Preload blocks 0x40..0x43 with 0xA0..0xA3 replicated; LATENCY=1; issue 4 back-to-back requests 0x40..0x43 with rsp.ready=1 -> rsp.valid on 4 consecutive cycles starting 1 cycle after the first accept, data 0xA0..0xA3 in order.
- LATENCY=3, QDEPTH=4; hold rsp.ready=0 and issue 6 requests -> exactly 4 accepted, req.ready=0 after the 4th; raise rsp.ready -> 4 in-order responses, req.ready reasserts the cycle after the first pop.
- Issue 4 requests, assert flush one cycle after the 2nd response -> no further rsp.valid; count=0; a new request to 0x10 is accepted the next cycle and its response arrives after LATENCY with the preloaded value.
- Write 0x55..55 to block 0x7 in the same cycle a read of 0x7 is accepted, then read again -> old data first, then 0x55..55.
- MEM_BLOCKS=1024; read address 0x405 -> without the macro, returns the block 0x005 contents; with MEM_RSP_BOUNDS_CHECK_EN, returns 0 and oob_err=1 stays set until rst.
- Assert rst while 3 responses are pending -> rsp.valid=0 the cycle after; no stale response after reset deasserts.
